// File: rtl/operand_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : operand_fetch_unit_pkg
// Brief    : Shared constants and types for the operand fetch unit.
// Revision : 1.0 - initial release
// ============================================================================
package operand_fetch_unit_pkg;

    localparam int NREGS = 16;
    localparam int WIDTH = 32;
    localparam int IDX_W = $clog2(NREGS);

    typedef logic [IDX_W-1:0] reg_idx_t;
    typedef logic [WIDTH-1:0] word_t;

    typedef struct packed {
        reg_idx_t rs_a;
        reg_idx_t rs_b;
        reg_idx_t rd;
        logic     rd_en;
    } operand_req_t;

endpackage
`default_nettype wire

// File: rtl/operand_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : operand_scoreboard
// Brief    : Per-register pending bits with RAW/WAW hazard detection.
// Revision : 1.0 - initial release
// ============================================================================
module operand_scoreboard
    import operand_fetch_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  operand_req_t     req,
    input  logic [NREGS-1:0] wb_we,
    input  logic             set_en,
    input  logic             clr_en,
    input  reg_idx_t         clr_idx,
    output logic [NREGS-1:0] pending,
    output logic             hazard
);

    logic [NREGS-1:0] r_pending;
    logic [NREGS-1:0] w_busy;
    logic [NREGS-1:0] w_set;
    logic [NREGS-1:0] w_clr;

    // A same-cycle writeback resolves the hazard; the bypass supplies the value.
    assign w_busy = r_pending & ~wb_we;
    assign hazard = w_busy[req.rs_a] | w_busy[req.rs_b] | (req.rd_en & w_busy[req.rd]);

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (set_en) w_set[req.rd] = 1'b1;
        if (clr_en) w_clr[clr_idx] = 1'b1;
    end

    // Set is OR-ed last so a new producer wins over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_pending <= '0;
        else     r_pending <= (r_pending & ~wb_we & ~w_clr) | w_set;
    end

    assign pending = r_pending;

endmodule
`default_nettype wire

// File: rtl/operand_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : operand_fetch_unit
// Brief    : Reads source operands with writeback bypass, scoreboard stalls
//            and a registered valid/ready output stage.
// Revision : 1.0 - initial release
// ============================================================================
module operand_fetch_unit
    import operand_fetch_unit_pkg::*;
#(
    parameter int STALL_W = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  word_t    [NREGS-1:0]        regs_in,
    input  logic     [NREGS-1:0]        wb_we,
    input  word_t    [NREGS-1:0]        wb_data,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  reg_idx_t                    req_rs_a,
    input  reg_idx_t                    req_rs_b,
    input  reg_idx_t                    req_rd,
    input  logic                        req_rd_en,
    output logic                        op_valid,
    input  logic                        op_ready,
    output word_t                       op_a,
    output word_t                       op_b,
    output reg_idx_t                    op_rd,
    output logic                        op_rd_en,
    input  logic                        flush,
    output logic     [NREGS-1:0]        pending,
    output logic     [STALL_W-1:0]      stall_count
);

    operand_req_t       w_req;
    logic               w_hazard;
    logic               w_space;
    logic               w_accept;
    logic               w_stall;
    word_t              w_val_a;
    word_t              w_val_b;

    logic               r_op_valid;
    word_t              r_op_a;
    word_t              r_op_b;
    reg_idx_t           r_op_rd;
    logic               r_op_rd_en;
    logic [STALL_W-1:0] r_stall;

    assign w_req = '{rs_a: req_rs_a, rs_b: req_rs_b, rd: req_rd, rd_en: req_rd_en};

    operand_scoreboard u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .req     (w_req),
        .wb_we   (wb_we),
        .set_en  (w_accept & req_rd_en),
        .clr_en  (flush & r_op_valid & r_op_rd_en),
        .clr_idx (r_op_rd),
        .pending (pending),
        .hazard  (w_hazard)
    );

    // regs_in still shows the old value during a writeback cycle.
    assign w_val_a = wb_we[req_rs_a] ? wb_data[req_rs_a] : regs_in[req_rs_a];
    assign w_val_b = wb_we[req_rs_b] ? wb_data[req_rs_b] : regs_in[req_rs_b];

    assign w_space   = ~r_op_valid | op_ready;
    assign req_ready = w_space & ~w_hazard & ~flush;
    assign w_accept  = req_valid & req_ready;
    assign w_stall   = req_valid & w_space & w_hazard & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_valid <= 1'b0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_op_rd    <= '0;
            r_op_rd_en <= 1'b0;
        end else if (flush) begin
            r_op_valid <= 1'b0;
        end else if (w_accept) begin
            r_op_valid <= 1'b1;
            r_op_a     <= w_val_a;
            r_op_b     <= w_val_b;
            r_op_rd    <= req_rd;
            r_op_rd_en <= req_rd_en;
        end else if (r_op_valid & op_ready) begin
            r_op_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  r_stall <= '0;
        else if (w_stall & ~&r_stall) r_stall <= r_stall + 1'b1;
    end

    assign op_valid    = r_op_valid;
    assign op_a        = r_op_a;
    assign op_b        = r_op_b;
    assign op_rd       = r_op_rd;
    assign op_rd_en    = r_op_rd_en;
    assign stall_count = r_stall;

endmodule
`default_nettype wire
